alu_issue: RTL and testbench

Execute-stage sequencer that sits directly upstream of the ALU (`c_alu`). It accepts one decoded operation at a time from the issue/decode stage and builds the ALU operands. It drives the ALU's level-sensitive `run`/`ack` handshake through a 2-flop ack synchronizer and captures the result. It then presents the result to writeback on a valid/ready interface, and flags ops the ALU cannot complete (MULT/DIV, handshake timeout) instead of hanging.

---
 rtl/alu_issue.sv | 165 ++++++++++++++++
 tb/tb_alu_issue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: execute-stage sequencer in front of the ALU.
// Builds operands, runs the run/ack handshake and returns the result.
module alu_issue #(
    parameter int OPR_L   = 32,
    parameter int ALUOP_L = 5,
    parameter int REG_L   = 5,
    parameter int TMO     = 16,
    parameter logic [ALUOP_L-1:0] ALU_MULT = ALUOP_L'(10),
    parameter logic [ALUOP_L-1:0] ALU_DIV  = ALUOP_L'(11)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_L-1:0] in_op,
    input  logic [OPR_L-1:0]   in_rs,
    input  logic [OPR_L-1:0]   in_rt,
    input  logic [15:0]        in_imm,
    input  logic               in_use_imm,
    input  logic               in_imm_sx,
    input  logic               in_c,
    input  logic [REG_L-1:0]   in_rd,
    output logic [OPR_L-1:0]   alu_A,
    output logic [OPR_L-1:0]   alu_B,
    output logic [ALUOP_L-1:0] alu_op,
    output logic               alu_c,
    output logic               alu_run,
    input  logic [OPR_L-1:0]   alu_Y,
    input  logic               alu_ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPR_L-1:0]   out_Y,
    output logic [REG_L-1:0]   out_rd,
    output logic               out_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WHI  = 2'd1;
    localparam logic [1:0] S_WLO  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [1:0]         state_q, state_d;
    logic               ack_m_q, ack_s_q;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [OPR_L-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
    logic [ALUOP_L-1:0] op_q, op_d;
    logic               c_q, c_d, run_q, run_d, err_q, err_d;
    logic [REG_L-1:0]   rd_q, rd_d;

    logic [OPR_L-1:0] imm_ext;
    logic             is_md;
    logic             tmr_max;

    assign imm_ext = in_imm_sx ? {{(OPR_L-16){in_imm[15]}}, in_imm}
                               : {{(OPR_L-16){1'b0}}, in_imm};
    assign is_md   = (in_op == ALU_MULT) || (in_op == ALU_DIV);
    assign tmr_max = (tmr_q == TW'(TMO - 1));

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        run_d   = run_q;
        y_d     = y_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = in_rs;
                    b_d   = in_use_imm ? imm_ext : in_rt;
                    op_d  = in_op;
                    c_d   = in_c;
                    rd_d  = in_rd;
                    y_d   = '0;
                    tmr_d = '0;
                    // The ALU cannot finish MULT/DIV; report instead of hanging
                    if (is_md) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        run_d   = 1'b1;
                        state_d = S_WHI;
                    end
                end
            end
            S_WHI: begin
                if (ack_s_q) begin
                    y_d     = alu_Y;
                    run_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = S_WLO;
                end else if (tmr_max) begin
                    run_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WLO: begin
                if (!ack_s_q) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (tmr_max) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
            tmr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            run_q   <= 1'b0;
            y_q     <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_m_q <= alu_ack;
            ack_s_q <= ack_m_q;
            tmr_q   <= tmr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            run_q   <= run_d;
            y_q     <= y_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && rst;
    assign out_valid = (state_q == S_DONE);
    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign alu_op    = op_q;
    assign alu_c     = c_q;
    assign alu_run   = run_q;
    assign out_Y     = y_q;
    assign out_rd    = rd_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed checks of alu_issue
// against a behavioural ALU/handshake model.
module tb_alu_issue;

    localparam logic [4:0] OP_MULT = 5'd10;
    localparam logic [4:0] OP_DIV  = 5'd11;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_rs = '0, in_rt = '0;
    logic [15:0] in_imm = '0;
    logic        in_use_imm = 1'b0, in_imm_sx = 1'b0, in_c = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] alu_A, alu_B, alu_Y;
    logic [4:0]  alu_op;
    logic        alu_c, alu_run, alu_ack;
    logic        out_valid, out_err;
    logic        out_ready = 1'b0;
    logic [31:0] out_Y;
    logic [4:0]  out_rd;

    // ack behaviour: 0 = ideal, 1 = dead (stuck 0), 2 = stuck 1 after raise
    int   mode = 0;
    logic hold = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    alu_issue #(.OPR_L(32), .ALUOP_L(5), .REG_L(5), .TMO(TMO),
                .ALU_MULT(OP_MULT), .ALU_DIV(OP_DIV)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_imm_sx(in_imm_sx), .in_c(in_c),
        .in_rd(in_rd),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_c(alu_c),
        .alu_run(alu_run), .alu_Y(alu_Y), .alu_ack(alu_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Y(out_Y), .out_rd(out_rd), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [4:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic c);
        case (op)
            5'd0:    return a + b + {31'd0, c};
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] ref_ext(input logic [15:0] imm,
                                            input logic sx);
        if (sx && imm >= 16'h8000) return 32'(imm) - 32'h10000;
        return 32'(imm);
    endfunction

    always @(posedge clk) begin
        if (mode != 2) hold <= 1'b0;
        else if (alu_run) hold <= 1'b1;
    end

    assign alu_ack = (mode == 0) ? alu_run :
                     (mode == 1) ? 1'b0 : (alu_run | hold);
    assign alu_Y = alu_f(alu_op, alu_A, alu_B, alu_c);

    task automatic issue(input logic [4:0] op, input logic [31:0] rs,
        input logic [31:0] rt, input logic [15:0] imm, input logic ui,
        input logic sx, input logic c, input logic [4:0] rd);
        in_op = op; in_rs = rs; in_rt = rt; in_imm = imm;
        in_use_imm = ui; in_imm_sx = sx; in_c = c; in_rd = rd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // k = edges after the accept edge until out_valid seen
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++; if ({alu_A, alu_B, alu_op, alu_c, alu_run} !== '0)
            $display("FAIL reset_alu: got %h/%h/%h/%b/%b want 0", alu_A,
                     alu_B, alu_op, alu_c, alu_run); else n_pass++;
        n_chk++; if ({out_Y, out_rd, out_err, out_valid, in_ready} !== '0)
            $display("FAIL reset_out: got %h/%h/%b/%b/%b want 0", out_Y,
                     out_rd, out_err, out_valid, in_ready); else n_pass++;
        rst = 1'b1; #1;
        n_chk++; if (in_ready !== 1'b1)
            $display("FAIL reset_rdy: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add;
        int k;
        mode = 0;
        issue(5'd0, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0, 1'b0, 5'd9);
        n_chk++; if (alu_B !== 32'd7 || alu_A !== 32'd5 || alu_run !== 1'b1)
            $display("FAIL add_opnd: got A=%h B=%h run=%b want 5/7/1",
                     alu_A, alu_B, alu_run); else n_pass++;
        wait_valid(k);
        n_chk++; if (k !== 6)
            $display("FAIL add_lat: got %0d want 6", k); else n_pass++;
        n_chk++; if (out_Y !== 32'd12 || out_rd !== 5'd9 || out_err !== 1'b0)
            $display("FAIL add_res: got Y=%h rd=%h err=%b want 12/9/0",
                     out_Y, out_rd, out_err); else n_pass++;
        release_out();
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL add_drop: got v=%b r=%b want 0/1",
                     out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_imm;
        int k;
        mode = 0;
        issue(5'd2, 32'h1234, 32'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 5'd1);
        n_chk++; if (alu_B !== 32'hFFFFFFFF)
            $display("FAIL imm_sx: got %h want ffffffff", alu_B); else n_pass++;
        wait_valid(k); release_out();
        issue(5'd2, 32'h1234, 32'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 5'd1);
        n_chk++; if (alu_B !== 32'h0000FFFF)
            $display("FAIL imm_zx: got %h want 0000ffff", alu_B); else n_pass++;
        wait_valid(k); release_out();
    endtask

    task automatic test_backpressure;
        int k;
        logic [31:0] y0;
        mode = 0;
        issue(5'd4, 32'hF0F0, 32'h0FF0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd3);
        wait_valid(k);
        y0 = out_Y;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b1 || out_Y !== y0 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b Y=%h r=%b want 1/%h/0",
                         i, out_valid, out_Y, in_ready, y0); else n_pass++;
        end
        n_chk++; if (y0 !== 32'hFF00)
            $display("FAIL bp_val: got %h want ff00", y0); else n_pass++;
        release_out();
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_rel: got v=%b r=%b want 0/1",
                     out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_mult;
        int k;
        mode = 0;
        issue(OP_MULT, 32'd3, 32'd4, 16'd0, 1'b0, 1'b0, 1'b1, 5'd7);
        wait_valid(k);
        n_chk++; if (k !== 0 || alu_run !== 1'b0)
            $display("FAIL mult_lat: got k=%0d run=%b want 0/0", k, alu_run);
        else n_pass++;
        n_chk++; if (out_err !== 1'b1 || out_Y !== 32'd0 || out_rd !== 5'd7)
            $display("FAIL mult_res: got err=%b Y=%h rd=%h want 1/0/7",
                     out_err, out_Y, out_rd); else n_pass++;
        n_chk++; if (alu_op !== OP_MULT || alu_c !== 1'b1 || alu_B !== 32'd4)
            $display("FAIL mult_opnd: got op=%h c=%b B=%h", alu_op, alu_c,
                     alu_B); else n_pass++;
        release_out();
    endtask

    task automatic test_timeout;
        int k;
        mode = 1;
        issue(5'd0, 32'd1, 32'd2, 16'd0, 1'b0, 1'b0, 1'b0, 5'd4);
        wait_valid(k);
        n_chk++; if (k !== TMO)
            $display("FAIL tmo_hi_lat: got %0d want %0d", k, TMO); else n_pass++;
        n_chk++; if (out_err !== 1'b1 || alu_run !== 1'b0 || out_Y !== 32'd0)
            $display("FAIL tmo_hi: got err=%b run=%b Y=%h want 1/0/0",
                     out_err, alu_run, out_Y); else n_pass++;
        release_out();
        mode = 2;
        issue(5'd1, 32'd100, 32'd30, 16'd0, 1'b0, 1'b0, 1'b0, 5'd5);
        wait_valid(k);
        mode = 0;
        n_chk++; if (k !== TMO + 3)
            $display("FAIL tmo_lo_lat: got %0d want %0d", k, TMO + 3);
        else n_pass++;
        n_chk++; if (out_err !== 1'b1 || out_Y !== 32'd70 || alu_run !== 1'b0)
            $display("FAIL tmo_lo: got err=%b Y=%h run=%b want 1/46/0",
                     out_err, out_Y, alu_run); else n_pass++;
        release_out();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int k;
        mode = 1;
        issue(5'd0, 32'hAA, 32'hBB, 16'd0, 1'b0, 1'b0, 1'b1, 5'd6);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk++; if (alu_run !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rmid_run: got run=%b r=%b want 0/0", alu_run,
                     in_ready); else n_pass++;
        n_chk++; if ({alu_A, alu_B, alu_op, alu_c, out_Y, out_rd, out_err,
                      out_valid} !== '0)
            $display("FAIL rmid_out: got A=%h B=%h Y=%h want all 0",
                     alu_A, alu_B, out_Y); else n_pass++;
        mode = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1)
            $display("FAIL rmid_rdy: got %b want 1", in_ready); else n_pass++;
        issue(5'd3, 32'h0F00, 32'h00F0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd2);
        wait_valid(k);
        n_chk++; if (k !== 6 || out_Y !== 32'h0FF0 || out_err !== 1'b0)
            $display("FAIL rmid_op: got k=%0d Y=%h err=%b want 6/ff0/0",
                     k, out_Y, out_err); else n_pass++;
        release_out();
    endtask

    task automatic test_random;
        int k, stall;
        logic [4:0] op, rd;
        logic [31:0] rs, rt, eb, ey;
        logic [15:0] imm;
        logic ui, sx, c, md;
        mode = 0;
        for (int i = 0; i < 25; i++) begin
            op = 5'($urandom_range(0, 6));
            if (op == 5'd5) op = OP_MULT;
            if (op == 5'd6) op = OP_DIV;
            rs = $urandom; rt = $urandom; imm = 16'($urandom);
            ui = 1'($urandom); sx = 1'($urandom); c = 1'($urandom);
            rd = 5'($urandom);
            md = (op == OP_MULT) || (op == OP_DIV);
            eb = ui ? ref_ext(imm, sx) : rt;
            ey = md ? 32'd0 : alu_f(op, rs, eb, c);
            n_chk++; if (in_ready !== 1'b1)
                $display("FAIL rnd%0d_rdy: got %b want 1", i, in_ready);
            else n_pass++;
            issue(op, rs, rt, imm, ui, sx, c, rd);
            n_chk++; if (alu_A !== rs || alu_B !== eb || alu_op !== op ||
                         alu_c !== c || alu_run !== !md)
                $display("FAIL rnd%0d_opnd: got A=%h B=%h run=%b want %h/%h/%b",
                         i, alu_A, alu_B, alu_run, rs, eb, !md);
            else n_pass++;
            wait_valid(k);
            n_chk++; if (k !== (md ? 0 : 6))
                $display("FAIL rnd%0d_lat: got %0d want %0d", i, k,
                         md ? 0 : 6); else n_pass++;
            stall = $urandom_range(0, 3);
            repeat (stall) @(posedge clk);
            #1;
            n_chk++; if (out_Y !== ey || out_rd !== rd || out_err !== md ||
                         out_valid !== 1'b1 || alu_B !== eb)
                $display("FAIL rnd%0d_res: got Y=%h rd=%h err=%b want %h/%h/%b",
                         i, out_Y, out_rd, out_err, ey, rd, md);
            else n_pass++;
            release_out();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(posedge clk); #1;
        test_add();
        test_imm();
        test_backpressure();
        test_mult();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
